// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM state encoding, parity modes, default baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  localparam bit CHECK_ODD  = 1'b1;
  localparam bit CHECK_EVEN = 1'b0;

  localparam int BAUD_NUM_DEFAULT = 50_000_000 / 115200;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the async rx line plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       rx_s_d_q;

  // Idle-high line: everything resets to 1 so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      rx_s_d_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], rx_i};
      rx_s_d_q <= sync_q[1];
    end
  end

  assign rx_s_o = sync_q[1];
  assign fall_o = rx_s_d_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8 data bits + parity + stop, mid-bit sampling.
// Optional `define UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter bit CHECK_MODE = CHECK_ODD,
  parameter int BAUD_NUM   = BAUD_NUM_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_data_valid,
  output logic [7:0] rx_data,
  output logic       rx_parity_err,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(BAUD_NUM);
  localparam logic [CW-1:0] LAST = CW'(BAUD_NUM - 1);

  uart_state_e   state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          par_err_q;
  logic          armed_q;
  logic          valid_q;
  logic [7:0]    data_q;
  logic          perr_q;
  logic          ferr_q;

  logic rx_s;
  logic fall;
  logic sample;
  logic at_dec;
  logic baud_end;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] PRE1 = CW'(BAUD_NUM / 2 - 2);
  localparam logic [CW-1:0] PRE0 = CW'(BAUD_NUM / 2 - 1);
  localparam logic [CW-1:0] DEC  = CW'(BAUD_NUM / 2);

  logic [1:0] maj_q;

  // Collect the samples at mid-1 and mid; the third vote is the live sample at mid+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      maj_q <= 2'b11;
    end else if (baud_cnt_q == PRE1 || baud_cnt_q == PRE0) begin
      maj_q <= {maj_q[0], rx_s};
    end
  end

  assign sample = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
`else
  localparam logic [CW-1:0] DEC = CW'(BAUD_NUM / 2 - 1);

  assign sample = rx_s;
`endif

  assign at_dec   = (baud_cnt_q == DEC);
  assign baud_end = (baud_cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      armed_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (state_q == IDLE || baud_end) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end

      if (state_q != DATA) begin
        bit_cnt_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (rx_s) begin
            armed_q <= 1'b1;
          end
          if (armed_q && fall) begin
            state_q <= START;
          end
        end
        START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (at_dec && sample) begin
            state_q <= IDLE;
          end else if (baud_end) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (at_dec) begin
            shreg_q[bit_cnt_q] <= sample;
          end
          if (baud_end) begin
            if (bit_cnt_q == 3'd7) begin
              state_q <= CHECK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        CHECK: begin
          if (at_dec) begin
            par_err_q <= sample ^ (^{shreg_q, CHECK_MODE});
          end
          if (baud_end) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          if (at_dec) begin
            valid_q <= 1'b1;
            data_q  <= shreg_q;
            perr_q  <= par_err_q;
            ferr_q  <= ~sample;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data_valid = valid_q;
  assign rx_data       = data_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx driven by an ideal tx model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BAUD = 16;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       rx   = 1'b1;
  logic       rx_e = 1'b1;
  logic       v, v_e;
  logic [7:0] d, d_e;
  logic       perr, perr_e, ferr, ferr_e;

  int tests = 0;
  int fails = 0;
  int vcnt = 0;
  int vcnt_e = 0;
  int base;
  logic [7:0] cap_data = '0;
  logic [7:0] prev_data = '0;
  logic [7:0] cap_e = '0;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;
  logic       cap_perr_e = 1'b0;

  uart_rx #(.CHECK_MODE(CHECK_ODD), .BAUD_NUM(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data_valid(v), .rx_data(d), .rx_parity_err(perr), .rx_frame_err(ferr)
  );

  uart_rx #(.CHECK_MODE(CHECK_EVEN), .BAUD_NUM(BAUD)) dut_even (
    .clk(clk), .rst(rst), .rx(rx_e),
    .rx_data_valid(v_e), .rx_data(d_e), .rx_parity_err(perr_e), .rx_frame_err(ferr_e)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (v) begin
      vcnt      <= vcnt + 1;
      prev_data <= cap_data;
      cap_data  <= d;
      cap_perr  <= perr;
      cap_ferr  <= ferr;
    end
    if (v_e) begin
      vcnt_e     <= vcnt_e + 1;
      cap_e      <= d_e;
      cap_perr_e <= perr_e;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic val, input bit even);
    if (even) rx_e = val;
    else      rx   = val;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input bit even);
    drive_bit(1'b0, even);
    for (int i = 0; i < 8; i++) drive_bit(b[i], even);
    drive_bit(p, even);
    drive_bit(s, even);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_valid", 32'(v), 32'd0);
    check("reset_data", 32'(d), 32'h00);
    check("reset_perr", 32'(perr), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);

    base = vcnt;
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    drive_bit(1'b1, 0);
    check("a5_count", 32'(vcnt - base), 32'd1);
    check("a5_data", 32'(cap_data), 32'hA5);
    check("a5_perr", 32'(cap_perr), 32'd0);
    check("a5_ferr", 32'(cap_ferr), 32'd0);

    base = vcnt;
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    drive_bit(1'b1, 0);
    check("a5bad_count", 32'(vcnt - base), 32'd1);
    check("a5bad_data", 32'(cap_data), 32'hA5);
    check("a5bad_perr", 32'(cap_perr), 32'd1);
    check("a5bad_ferr", 32'(cap_ferr), 32'd0);

    send_frame(8'hA5, 1'b0, 1'b1, 1);
    drive_bit(1'b1, 1);
    check("even_count", 32'(vcnt_e), 32'd1);
    check("even_data", 32'(cap_e), 32'hA5);
    check("even_perr", 32'(cap_perr_e), 32'd0);

    base = vcnt;
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    check("break_count", 32'(vcnt - base), 32'd1);
    check("break_data", 32'(cap_data), 32'h3C);
    check("break_ferr", 32'(cap_ferr), 32'd1);
    check("break_perr", 32'(cap_perr), 32'd0);
    repeat (100) @(negedge clk);
    check("break_low_count", 32'(vcnt - base), 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("break_rise_count", 32'(vcnt - base), 32'd1);

    base = vcnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (9) @(negedge clk);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    repeat (30) @(negedge clk);
    check("glitch_count", 32'(vcnt - base), 32'd0);
    send_frame(8'h01, 1'b0, 1'b1, 0);
    drive_bit(1'b1, 0);
    check("after_glitch_count", 32'(vcnt - base), 32'd1);
    check("after_glitch_data", 32'(cap_data), 32'h01);
    check("after_glitch_perr", 32'(cap_perr), 32'd0);

    base = vcnt;
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    drive_bit(1'b1, 0);
    check("b2b_count", 32'(vcnt - base), 32'd2);
    check("b2b_first", 32'(prev_data), 32'h00);
    check("b2b_second", 32'(cap_data), 32'hFF);
    check("b2b_perr", 32'(cap_perr), 32'd0);
    check("b2b_ferr", 32'(cap_ferr), 32'd0);

    base = vcnt;
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i), 0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check("rst_valid", 32'(v), 32'd0);
    check("rst_data", 32'(d), 32'h00);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    check("rst_count", 32'(vcnt - base), 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 0);
    drive_bit(1'b1, 0);
    check("post_rst_count", 32'(vcnt - base), 32'd1);
    check("post_rst_data", 32'(cap_data), 32'h55);
    check("post_rst_perr", 32'(cap_perr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
